// File: rtl/pb_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_event_pkg
//  Description : Shared types and default timing constants for the
//                push-button gesture decoder and its debouncer wrapper.
//  Revision    : 1.0  initial release
// ============================================================================
package pb_event_pkg;

    // Gesture classifier states
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        HELD        = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_SECOND = 3'd3,
        SECOND_HELD = 3'd4
    } pb_evt_state_t;

    // Default gesture timing in base-clock cycles (1 s / 0.2 s / 0.5 s at 50 MHz)
    localparam int c_long_cycles_def   = 50_000_000;
    localparam int c_repeat_cycles_def = 10_000_000;
    localparam int c_dclick_cycles_def = 25_000_000;

    // Largest of three cycle limits; sizes the shared gesture timer
    function automatic int pb_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage : pb_event_pkg
`default_nettype wire

// File: rtl/pb_cycle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pb_cycle_timer
//  Description : Free-running cycle counter with synchronous clear and
//                count enable. Clear has priority over enable.
//  Revision    : 1.0  initial release
// ============================================================================
module pb_cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    // Count up while enabled; clear returns to zero on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : pb_cycle_timer
`default_nettype wire

// File: rtl/pb_event_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : pb_event_decoder
//  Description : Classifies debounced press/release pulses into short press,
//                long press, auto-repeat and double-click events. All event
//                outputs are registered single-cycle pulses; held is a level.
//  Revision    : 1.0  initial release
// ============================================================================
module pb_event_decoder
    import pb_event_pkg::*;
#(
    parameter int LONG_CYCLES   = c_long_cycles_def,
    parameter int REPEAT_CYCLES = c_repeat_cycles_def,
    parameter int DCLICK_CYCLES = c_dclick_cycles_def
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed_pulse,
    input  logic released_pulse,
    output logic short_press,
    output logic long_press,
    output logic repeat_pulse,
    output logic double_click,
    output logic held
);

    // Timer only needs to reach (limit - 1) of the largest limit
    localparam int c_max_cycles = pb_max3(LONG_CYCLES, REPEAT_CYCLES, DCLICK_CYCLES);
    localparam int c_cnt_w      = $clog2(c_max_cycles);

    localparam logic [c_cnt_w-1:0] c_long_last   = c_cnt_w'(LONG_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_repeat_last = c_cnt_w'(REPEAT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_dclick_last = c_cnt_w'(DCLICK_CYCLES - 1);

    pb_evt_state_t      r_state;
    pb_evt_state_t      w_next_state;
    logic [c_cnt_w-1:0] w_cnt;
    logic               w_press;
    logic               w_timer_clear;
    logic               w_timer_en;
    logic               w_short;
    logic               w_long;
    logic               w_repeat;
    logic               w_dclick;
    logic               w_next_held;
    logic               r_short;
    logic               r_long;
    logic               r_repeat;
    logic               r_dclick;
    logic               r_held;

    // A simultaneous release overrides the press
    assign w_press = pressed_pulse & ~released_pulse;

    // Timer restarts on every state change and on each auto-repeat;
    // it is parked in IDLE so it can never wrap
    assign w_timer_clear = (w_next_state != r_state) | w_repeat;
    assign w_timer_en    = (r_state != IDLE);

    pb_cycle_timer #(
        .WIDTH (c_cnt_w)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_timer_clear),
        .enable (w_timer_en),
        .count  (w_cnt)
    );

    // Next-state and event decode
    always_comb begin
        w_next_state = r_state;
        w_short      = 1'b0;
        w_long       = 1'b0;
        w_repeat     = 1'b0;
        w_dclick     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_press) begin
                    w_next_state = HELD;
                end
            end
            HELD: begin
                if (released_pulse) begin
                    w_next_state = WAIT_SECOND;
                end else if (w_cnt == c_long_last) begin
                    w_next_state = LONG_HELD;
                    w_long       = 1'b1;
                end
            end
            LONG_HELD: begin
                if (released_pulse) begin
                    w_next_state = IDLE;
                end else if (w_cnt == c_repeat_last) begin
                    w_repeat = 1'b1;
                end
            end
            WAIT_SECOND: begin
                if (w_press) begin
                    w_next_state = SECOND_HELD;
                end else if (w_cnt == c_dclick_last) begin
                    w_next_state = IDLE;
                    w_short      = 1'b1;
                end
            end
            SECOND_HELD: begin
                if (released_pulse) begin
                    w_next_state = IDLE;
                    w_dclick     = 1'b1;
                end else if (w_cnt == c_long_last) begin
                    // Hold after a first click becomes a long press; first click dropped
                    w_next_state = LONG_HELD;
                    w_long       = 1'b1;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_next_held = (w_next_state == HELD) ||
                         (w_next_state == LONG_HELD) ||
                         (w_next_state == SECOND_HELD);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_repeat <= 1'b0;
            r_dclick <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_short  <= w_short;
            r_long   <= w_long;
            r_repeat <= w_repeat;
            r_dclick <= w_dclick;
            r_held   <= w_next_held;
        end
    end

    assign short_press  = r_short;
    assign long_press   = r_long;
    assign repeat_pulse = r_repeat;
    assign double_click = r_dclick;
    assign held         = r_held;

endmodule : pb_event_decoder
`default_nettype wire
